// File: rtl/mm_adder.sv
// Tiled element-wise matrix accumulator: adds M_TILE x N_TILE tiles into an
// M x N buffer and streams the buffer out one row per enabled cycle.
module mm_adder #(
  parameter int M      = 4,
  parameter int N      = 4,
  parameter int M_TILE = 2,
  parameter int N_TILE = 2,
  parameter int DW_ADD = 32,
  parameter int DW_INT = 8,
  parameter int DW_IN  = DW_ADD * M_TILE * N_TILE,
  parameter int DW_OUT = DW_ADD * N
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DW_INT-1:0] ptr_row,
  input  logic [DW_INT-1:0] ptr_col,
  input  logic [DW_IN-1:0]  in,
  input  logic              in_valid,
  output logic [DW_OUT-1:0] out
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;

  logic [DW_ADD-1:0] acc_reg  [M][N];
  logic [DW_ADD-1:0] acc_next [M][N];
  logic [RW-1:0]     rd_row_reg;
  logic [DW_OUT-1:0] out_reg;
  logic [DW_OUT-1:0] rd_data;
  logic [31:0]       row_base;
  logic [31:0]       col_base;

  assign row_base = 32'(ptr_row) * 32'(M_TILE);
  assign col_base = 32'(ptr_col) * 32'(N_TILE);

  // Each buffer cell works out whether the current tile covers it. Offsets
  // below the tile base wrap to huge unsigned values and never match, so
  // out-of-range tile elements simply find no cell.
  genvar gi, gj;
  generate
    for (gi = 0; gi < M; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        logic [31:0]       mi;
        logic [31:0]       ni;
        logic              hit;
        logic [DW_ADD-1:0] elem;

        assign mi = 32'(gi) - row_base;
        assign ni = 32'(gj) - col_base;

        always_comb begin
          hit  = 1'b0;
          elem = '0;
          if (in_valid) begin
            for (int a = 0; a < M_TILE; a++) begin
              for (int b = 0; b < N_TILE; b++) begin
                if (mi == 32'(a) && ni == 32'(b)) begin
                  hit  = 1'b1;
                  elem = in[DW_ADD*(a*N_TILE+b) +: DW_ADD];
                end
              end
            end
          end
        end

        assign acc_next[gi][gj] = hit ? (acc_reg[gi][gj] + elem) : acc_reg[gi][gj];
      end
    end
  endgenerate

  // Readout samples the buffer before this edge's accumulate lands.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < N; c++) begin
      rd_data[DW_ADD*c +: DW_ADD] = acc_reg[rd_row_reg][c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < N; c++) begin
          acc_reg[r][c] <= '0;
        end
      end
      rd_row_reg <= '0;
      out_reg    <= '0;
    end else if (enable) begin
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < N; c++) begin
          acc_reg[r][c] <= acc_next[r][c];
        end
      end
      out_reg    <= rd_data;
      rd_row_reg <= (rd_row_reg == RW'(M - 1)) ? '0 : rd_row_reg + 1'b1;
    end
  end

  assign out = out_reg;

endmodule

// File: tb/tb_mm_adder.sv
// Directed bench for mm_adder (4x4 buffer, 2x2 tiles, 32-bit elements).
module tb_mm_adder;

  localparam int M = 4;
  localparam int N = 4;
  localparam int DW_IN  = 128;
  localparam int DW_OUT = 128;

  typedef int mat_t [16];

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic [7:0]        ptr_row = '0;
  logic [7:0]        ptr_col = '0;
  logic [DW_IN-1:0]  in = '0;
  logic              in_valid = 1'b0;
  logic [DW_OUT-1:0] out;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_model = 0;

  mat_t mat_a, mat_b, mat_s, mat_z, mat_t1, mat_t2, mat_e;

  mm_adder dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .ptr_row (ptr_row),
    .ptr_col (ptr_col),
    .in      (in),
    .in_valid(in_valid),
    .out     (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW_OUT-1:0] obs, input logic [DW_OUT-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance one edge and track which row the readout scan is on.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) rd_model = 0;
    else if (enable) rd_model = (rd_model + 1) % M;
  endtask

  function automatic logic [DW_OUT-1:0] row_of(input mat_t m, input int r);
    logic [DW_OUT-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[32*c +: 32] = m[r*N+c];
    return v;
  endfunction

  function automatic logic [DW_IN-1:0] pack_tile(input mat_t m, input int tr, input int tc);
    logic [DW_IN-1:0] v;
    v = '0;
    for (int mi = 0; mi < 2; mi++)
      for (int ni = 0; ni < 2; ni++)
        v[32*(mi*2+ni) +: 32] = m[(tr*2+mi)*N + tc*2+ni];
    return v;
  endfunction

  task automatic feed_tile(input int tr, input int tc, input logic [DW_IN-1:0] data);
    enable   = 1'b1;
    in_valid = 1'b1;
    ptr_row  = 8'(tr);
    ptr_col  = 8'(tc);
    in       = data;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic feed_mat(input mat_t m);
    for (int tr = 0; tr < 2; tr++)
      for (int tc = 0; tc < 2; tc++)
        feed_tile(tr, tc, pack_tile(m, tr, tc));
  endtask

  task automatic read_all(input mat_t m, input string tag);
    int r;
    enable   = 1'b1;
    in_valid = 1'b0;
    repeat (M) begin
      r = rd_model;
      tick();
      check($sformatf("%s_row%0d", tag, r), out, row_of(m, r));
    end
  endtask

  task automatic wait_row(input int r);
    enable   = 1'b1;
    in_valid = 1'b0;
    while (rd_model != r) tick();
  endtask

  task automatic do_reset(input logic en);
    reset  = 1'b1;
    enable = en;
    in_valid = 1'b0;
    tick();
    reset  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mat_a[i] = i;
      mat_b[i] = 100 + i;
      mat_s[i] = 100 + 2*i;
      mat_z[i] = 0;
    end

    // Reset with enable low, then an idle scan of zeros
    do_reset(1'b0);
    check("reset_out", out, '0);
    read_all(mat_z, "reset_scan");

    // A then B leaves A+B
    feed_mat(mat_a);
    feed_mat(mat_b);
    read_all(mat_s, "sum");
    wait_row(0);
    tick();
    check("sum_row0_const", out, {32'd106, 32'd104, 32'd102, 32'd100});
    wait_row(3);
    tick();
    check("sum_row3_const", out, {32'd130, 32'd128, 32'd126, 32'd124});

    // Signed: -5 + 3
    do_reset(1'b0);
    mat_t1 = mat_z; mat_t1[0] = -5;
    mat_t2 = mat_z; mat_t2[0] = 3;
    feed_tile(0, 0, pack_tile(mat_t1, 0, 0));
    feed_tile(0, 0, pack_tile(mat_t2, 0, 0));
    wait_row(0);
    tick();
    check("signed_row0", out, {32'd0, 32'd0, 32'd0, 32'hFFFFFFFE});

    // Wrap: 0x7FFFFFFF + 1
    do_reset(1'b0);
    mat_t1 = mat_z; mat_t1[0] = 32'h7FFFFFFF;
    mat_t2 = mat_z; mat_t2[0] = 1;
    feed_tile(0, 0, pack_tile(mat_t1, 0, 0));
    feed_tile(0, 0, pack_tile(mat_t2, 0, 0));
    wait_row(0);
    tick();
    check("wrap_row0", out, {32'd0, 32'd0, 32'd0, 32'h80000000});

    // Hold: enable low with valid data 7 must change nothing
    do_reset(1'b0);
    feed_mat(mat_a);
    wait_row(3);
    tick();
    check("hold_pre", out, row_of(mat_a, 3));
    enable   = 1'b0;
    in_valid = 1'b1;
    ptr_row  = 8'd0;
    ptr_col  = 8'd0;
    in       = {4{32'd7}};
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold_out%0d", k), out, row_of(mat_a, 3));
    end
    in_valid = 1'b0;
    read_all(mat_a, "hold_after");

    // Out-of-range tiles are dropped
    feed_tile(2, 0, {4{32'd9}});
    feed_tile(0, 2, {4{32'd9}});
    feed_tile(2, 2, {4{32'd9}});
    read_all(mat_a, "oor");

    // Reset mid-operation (reset beats enable) then B only
    do_reset(1'b1);
    check("midreset_out", out, '0);
    feed_mat(mat_b);
    read_all(mat_b, "midreset_b");

    // A twice gives 2A
    do_reset(1'b0);
    feed_mat(mat_a);
    feed_mat(mat_a);
    for (int i = 0; i < 16; i++) mat_e[i] = 2*i;
    read_all(mat_e, "double_a");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
